regdump: RTL and testbench

Register-file dump controller for the 8×16-bit CPU register file. It is the reader-side counterpart of the register file's write port. On a start pulse it walks every register through a read-index port, captures each 16-bit value, and streams a framed byte sequence over a valid/ready byte interface to the board's UART/debug transmitter. It sits beside the processor core and uses one of the register file's combinational read ports while `busy` is high.

---
 rtl/regdump_pkg.sv | 17 +
 rtl/regdump_if.sv | 22 ++
 rtl/regdump.sv | 134 +++++++++++++
 tb/tb_regdump.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared CPU defines for the register-file dump controller: register file
// geometry, frame header byte and dump FSM state encodings.
package regdump_pkg;

  localparam int unsigned REG_COUNT = 8;
  localparam int unsigned REG_W     = 16;
  localparam int unsigned REG_AW    = 3;
  localparam logic [7:0]  DUMP_SYNC = 8'hA5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_HI   = 3'd3;
  localparam logic [2:0] ST_LO   = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;

endpackage

// File: rtl/regdump_if.sv
// Dump-side bus: register file read port plus the valid/ready byte stream
// towards the UART/debug transmitter.
interface regdump_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 16
);
  logic [AW-1:0] rsel;
  logic [DW-1:0] rdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  modport master (
    output rsel, tx_data, tx_valid,
    input  rdata, tx_ready
  );

  modport slave (
    input  rsel, tx_data, tx_valid,
    output rdata, tx_ready
  );
endinterface

// File: rtl/regdump.sv
// Register-file dump controller: sweeps every register through the read port
// and streams SYNC, hi/lo byte pairs and an XOR checksum over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; rsel holds its last value
// SYNC  | presenting the header byte
// LOAD  | capturing rdata for rsel into hold; no byte presented
// HI    | presenting hold[15:8]
// LO    | presenting hold[7:0]; advances rsel or goes to CSUM
// CSUM  | presenting the checksum; done pulses after it transfers
module regdump
  import regdump_pkg::*;
#(
  parameter int unsigned NREGS = REG_COUNT,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_W,
  parameter logic [7:0]  SYNC  = DUMP_SYNC
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  output logic      busy,
  output logic      done,
  regdump_if.master bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] rsel_q, rsel_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [7:0]    csum_q, csum_d;
  logic          done_q, done_d;
  logic          xfer;

  assign xfer = bus.tx_valid && bus.tx_ready;

  always_comb begin
    state_d = state_q;
    rsel_d  = rsel_q;
    hold_d  = hold_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC;
          rsel_d  = '0;
          csum_d  = '0;
        end
      end
      ST_SYNC: begin
        if (xfer) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        hold_d  = bus.rdata;
        state_d = ST_HI;
      end
      ST_HI: begin
        if (xfer) begin
          csum_d  = csum_q ^ hold_q[DW-1:DW-8];
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (xfer) begin
          csum_d = csum_q ^ hold_q[7:0];
          if (rsel_q == LAST_IDX) begin
            state_d = ST_CSUM;
          end else begin
            rsel_d  = rsel_q + AW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rsel_q  <= '0;
      hold_q  <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      hold_q  <= hold_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  // Byte lane is a pure decode of registered state, so tx_ready never reaches an output.
  always_comb begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    case (state_q)
      ST_SYNC: begin
        bus.tx_data  = SYNC;
        bus.tx_valid = 1'b1;
      end
      ST_HI: begin
        bus.tx_data  = hold_q[DW-1:DW-8];
        bus.tx_valid = 1'b1;
      end
      ST_LO: begin
        bus.tx_data  = hold_q[7:0];
        bus.tx_valid = 1'b1;
      end
      ST_CSUM: begin
        bus.tx_data  = csum_q;
        bus.tx_valid = 1'b1;
      end
      default: begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
      end
    endcase
  end

  assign bus.rsel = rsel_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_regdump.sv
// Directed bench for regdump: fixed register images, hand-computed frames,
// back-pressure, ignored restarts, mid-frame reset and back-to-back dumps.
module tb_regdump;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  regdump_if #(.AW(3), .DW(16)) bus ();

  logic [15:0] rf [8];
  assign bus.rdata = rf[bus.rsel];

  regdump u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // r3 = 12AB, all others zero
  logic [7:0] exp_a [18] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h12, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'hB9};
  // r_i = 0100 + i
  logic [7:0] exp_b [18] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02,
                             8'h01, 8'h03, 8'h01, 8'h04, 8'h01, 8'h05, 8'h01,
                             8'h06, 8'h01, 8'h07, 8'h00};

  logic [7:0] byte_q [$];
  int   rel_cyc, done_cnt, done_first, done_last, gap_cnt, stab_err;
  logic pend;
  logic [7:0] pend_data;
  logic c1_valid, c1_busy;
  logic [7:0] c1_data;

  task automatic sample_cycle();
    rel_cyc++;
    if (rel_cyc == 1) begin
      c1_valid = bus.tx_valid;
      c1_busy  = busy;
      c1_data  = bus.tx_data;
    end
    if (pend && !(bus.tx_valid && bus.tx_data == pend_data)) stab_err++;
    pend      = bus.tx_valid && !bus.tx_ready;
    pend_data = bus.tx_data;
    if (bus.tx_valid && bus.tx_ready) byte_q.push_back(bus.tx_data);
    if (busy && !bus.tx_valid) gap_cnt++;
    if (done) begin
      done_cnt++;
      if (done_first == 0) done_first = rel_cyc;
      done_last = rel_cyc;
    end
  endtask

  task automatic cmp_frame(input string tag, input int base, input logic [7:0] exp [18]);
    for (int i = 0; i < 18; i++) begin
      logic [31:0] act;
      act = (base + i < byte_q.size()) ? 32'(byte_q[base + i]) : 32'hDEAD;
      check_eq($sformatf("%s byte%0d", tag, i), act, 32'(exp[i]));
    end
  endtask

  // mode 0: ready=1; 1: ready 1010 with a 5-cycle stall on r5 LO;
  // 2: extra start at byte 4; 3: restart in the done cycle; 4: reset after byte 7
  task automatic run_frame(input int mode, input int ncyc);
    int   stall;
    logic fired;
    logic rchk;
    byte_q.delete();
    rel_cyc = 0; done_cnt = 0; done_first = 0; done_last = 0;
    gap_cnt = 0; stab_err = 0; pend = 1'b0;
    stall = 0; fired = 1'b0; rchk = 1'b0;
    start = 1'b1;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      start = 1'b0;
      bus.tx_ready = 1'b1;
      if (mode == 1) begin
        bus.tx_ready = (cyc % 2 == 0);
        if (byte_q.size() == 12 && bus.tx_valid && stall < 5) begin
          bus.tx_ready = 1'b0;
          stall++;
        end
      end
      if (mode == 2 && !fired && byte_q.size() == 4) begin
        start = 1'b1;
        fired = 1'b1;
      end
      if (mode == 3 && !fired && done) begin
        start = 1'b1;
        fired = 1'b1;
      end
      if (mode == 4) begin
        if (fired && !rchk) begin
          rchk = 1'b1;
          check_eq("rst_mid tx_valid", 32'(bus.tx_valid), 32'd0);
          check_eq("rst_mid busy", 32'(busy), 32'd0);
          check_eq("rst_mid rsel", 32'(bus.rsel), 32'd0);
          check_eq("rst_mid tx_data", 32'(bus.tx_data), 32'd0);
        end
        if (!fired && byte_q.size() == 7) begin
          reset = 1'b0;
          fired = 1'b1;
        end else begin
          reset = 1'b1;
        end
      end
      @(negedge clk);
      sample_cycle();
      @(posedge clk); #1;
    end
    start = 1'b0;
    reset = 1'b1;
    bus.tx_ready = 1'b1;
  endtask

  initial begin
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rf[3] = 16'h12AB;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset rsel", 32'(bus.rsel), 32'd0);
    check_eq("reset tx_valid", 32'(bus.tx_valid), 32'd0);
    check_eq("reset tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 40);
    check_eq("s1 first valid", 32'(c1_valid), 32'd1);
    check_eq("s1 first busy", 32'(c1_busy), 32'd1);
    check_eq("s1 first data", 32'(c1_data), 32'hA5);
    check_eq("s1 len", 32'(byte_q.size()), 32'd18);
    cmp_frame("s1", 0, exp_a);
    check_eq("s1 done cycle", 32'(done_first), 32'd27);
    check_eq("s1 done count", 32'(done_cnt), 32'd1);
    check_eq("s1 valid gaps", 32'(gap_cnt), 32'd8);

    for (int i = 0; i < 8; i++) rf[i] = 16'h0100 + 16'(i);
    run_frame(0, 40);
    check_eq("s2 len", 32'(byte_q.size()), 32'd18);
    cmp_frame("s2", 0, exp_b);
    check_eq("s2 done count", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rf[3] = 16'h12AB;
    run_frame(1, 120);
    check_eq("s3 len", 32'(byte_q.size()), 32'd18);
    cmp_frame("s3", 0, exp_a);
    check_eq("s3 stable while stalled", 32'(stab_err), 32'd0);
    check_eq("s3 done count", 32'(done_cnt), 32'd1);
    check_eq("s3 valid gaps", 32'(gap_cnt), 32'd8);

    run_frame(2, 80);
    check_eq("s4 len", 32'(byte_q.size()), 32'd18);
    cmp_frame("s4", 0, exp_a);
    check_eq("s4 done count", 32'(done_cnt), 32'd1);

    run_frame(4, 60);
    check_eq("s5 partial len", 32'(byte_q.size()), 32'd7);
    check_eq("s5 no done", 32'(done_cnt), 32'd0);
    run_frame(0, 40);
    check_eq("s5 restart len", 32'(byte_q.size()), 32'd18);
    cmp_frame("s5 restart", 0, exp_a);
    check_eq("s5 restart done", 32'(done_cnt), 32'd1);

    run_frame(3, 80);
    check_eq("s6 len", 32'(byte_q.size()), 32'd36);
    cmp_frame("s6 f1", 0, exp_a);
    cmp_frame("s6 f2", 18, exp_a);
    check_eq("s6 done count", 32'(done_cnt), 32'd2);
    check_eq("s6 done1 cycle", 32'(done_first), 32'd27);
    check_eq("s6 done2 cycle", 32'(done_last), 32'd54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
